// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
//   Bundles the EX/MEM inputs and the branch / stall / MEM-WB outputs of the
//   MEM pipeline stage.
//   slave  : the MEM stage itself (consumes EX/MEM, produces MEM/WB).
//   master : the surrounding pipeline or a testbench driving the stage.
// Signals
//   bitsCtr[4:0]   [4]regWrite [3]memToReg [2]branch [1]memRead [0]memWrite
//   resultadoAdd   branch target from EX
//   zero           ALU zero flag
//   resultadoUla   ALU result / byte address
//   saidaRead2     store data (rt)
//   saidaMux5b     destination register number
//   pcSrc          branch taken
//   branchTarget   branch target passed through
//   stall          freeze upstream stages this cycle
//   wbCtr[1:0]     MEM/WB control: [1]regWrite [0]memToReg
//   dadoMem        MEM/WB load data
//   resultadoUlaWb MEM/WB ALU result
//   regDestWb      MEM/WB destination register
// -----------------------------------------------------------------------------
interface mem_stage_if;
  logic [4:0]  bitsCtr;
  logic [31:0] resultadoAdd;
  logic        zero;
  logic [31:0] resultadoUla;
  logic [31:0] saidaRead2;
  logic [4:0]  saidaMux5b;
  logic        pcSrc;
  logic [31:0] branchTarget;
  logic        stall;
  logic [1:0]  wbCtr;
  logic [31:0] dadoMem;
  logic [31:0] resultadoUlaWb;
  logic [4:0]  regDestWb;

  modport slave (
    input  bitsCtr, resultadoAdd, zero, resultadoUla, saidaRead2, saidaMux5b,
    output pcSrc, branchTarget, stall, wbCtr, dadoMem, resultadoUlaWb, regDestWb
  );

  modport master (
    output bitsCtr, resultadoAdd, zero, resultadoUla, saidaRead2, saidaMux5b,
    input  pcSrc, branchTarget, stall, wbCtr, dadoMem, resultadoUlaWb, regDestWb
  );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   MEM stage of a 5-stage MIPS pipeline: word-addressed data RAM with a
//   MEM_LAT-cycle access, branch resolution, stall generation while an access
//   is in flight, and the MEM/WB pipeline register.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    mem_stage_if.slave (EX/MEM inputs, branch/stall/MEM-WB outputs)
// Parameters
//   MEM_WORDS  RAM depth in 32-bit words (power of two)
//   MEM_LAT    cycles a load/store occupies the stage (>= 1)
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int MEM_WORDS = 256,
  parameter int MEM_LAT   = 2
) (
  input  logic     clk,
  input  logic     reset,
  mem_stage_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);
  // Counter only has to reach MEM_LAT-2; keep at least one bit for LAT<=2.
  localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_c;
  logic          retire;   // instruction leaves the stage at this edge

  logic [1:0]    wb_ctr_q;
  logic [31:0]   dado_mem_q;
  logic [31:0]   alu_wb_q;
  logic [4:0]    reg_dest_q;

  logic [31:0]   ram [MEM_WORDS];

  logic          mem_op;
  logic [AW-1:0] addr;
  logic          unused_addr_bits;

  assign mem_op = bus.bitsCtr[1] | bus.bitsCtr[0];
  // Byte address -> word index; upper bits drop so accesses wrap.
  assign addr   = bus.resultadoUla[AW+1:2];
  assign unused_addr_bits = ^{bus.resultadoUla[31:AW+2], bus.resultadoUla[1:0]};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && (MEM_LAT > 1)) begin
          stall_c = 1'b1;
          state_d = ST_BUSY;
          cnt_d   = CW'(MEM_LAT - 2);
        end else begin
          retire = 1'b1;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A store still presented while reset is low must not freeze the pipeline.
  assign bus.stall        = reset & stall_c;
  assign bus.pcSrc        = bus.bitsCtr[2] & bus.zero;
  assign bus.branchTarget = bus.resultadoAdd;

  // NOTE: the RAM array has no reset; only its write enable is qualified by reset so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (reset && retire && bus.bitsCtr[0]) begin
      ram[addr] <= bus.saidaRead2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wb_ctr_q   <= '0;
      dado_mem_q <= '0;
      alu_wb_q   <= '0;
      reg_dest_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values, including the old RAM word.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (retire) begin
        wb_ctr_q   <= bus.bitsCtr[4:3];
        dado_mem_q <= ram[addr];
        alu_wb_q   <= bus.resultadoUla;
        reg_dest_q <= bus.saidaMux5b;
      end else begin
        // Bubble: kill write-back, hold the data fields.
        wb_ctr_q <= 2'b00;
      end
    end
  end

  assign bus.wbCtr          = wb_ctr_q;
  assign bus.dadoMem        = dado_mem_q;
  assign bus.resultadoUlaWb = alu_wb_q;
  assign bus.regDestWb      = reg_dest_q;

endmodule
